if_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage pipeline CPU. Owns the PC register and the
//  IF/ID pipeline register. Drives the byte address into the combinational instruction

---
 rtl/if_stage.sv | 107 ++++++++++
 tb/tb_if_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID pipeline register, fetching
// from a zero-latency instruction memory with stall, redirect/flush and PC wrap.
module if_stage #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        misalign,
    output logic [31:0] fetch_count
);

    localparam int unsigned AW        = 32;
    localparam logic [AW-1:0] ADDR_MASK = AW'(MEM_BYTES - 1);
    localparam logic [AW-1:0] WORD_STEP = AW'(4);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [AW-1:0]   ii_instr_q, ii_instr_d;
    logic [AW-1:0]   ii_pc4_q, ii_pc4_d;
    logic            ii_valid_q, ii_valid_d;
    logic            misalign_q, misalign_d;
    logic [AW-1:0]   count_q, count_d;
    logic [AW-1:0]   pc_plus4;

    assign pc_plus4 = pc_q + WORD_STEP;

    // Next-state: redirect beats stall beats sequential fetch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ii_instr_d = ii_instr_q;
        ii_pc4_d   = ii_pc4_q;
        ii_valid_d = ii_valid_q;
        misalign_d = misalign_q;
        count_d    = count_q;

        case (state_q)
            BOOT: begin
                state_d    = RUN;
                ii_instr_d = '0;
                ii_pc4_d   = '0;
                ii_valid_d = 1'b0;
            end
            RUN: begin
                if (redirect) begin
                    pc_d       = {redirect_pc[31:2], 2'b00} & ADDR_MASK;
                    ii_instr_d = '0;
                    ii_pc4_d   = '0;
                    ii_valid_d = 1'b0;
                    if (redirect_pc[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                    end
                end else if (!stall) begin
                    // if_id_pc4 keeps the unwrapped value; only the PC wraps.
                    ii_instr_d = instr;
                    ii_pc4_d   = pc_plus4;
                    ii_valid_d = 1'b1;
                    pc_d       = pc_plus4 & ADDR_MASK;
                    count_d    = count_q + AW'(1);
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= PC_RESET;
            ii_instr_q <= '0;
            ii_pc4_q   <= '0;
            ii_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ii_instr_q <= ii_instr_d;
            ii_pc4_q   <= ii_pc4_d;
            ii_valid_q <= ii_valid_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
        end
    end

    assign instr_addr  = pc_q;
    assign if_id_instr = ii_instr_q;
    assign if_id_pc4   = ii_pc4_q;
    assign if_id_valid = ii_valid_q;
    assign misalign    = misalign_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random stall/redirect traffic,
// compared each cycle against a behavioural fetch model.
module tb_if_stage;

    localparam int MEM_BYTES = 128;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_addr;
    logic [31:0] instr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        misalign;
    logic [31:0] fetch_count;

    logic [7:0] mem [MEM_BYTES];

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model state
    bit          m_boot;
    int unsigned m_pc;
    logic [31:0] m_instr;
    int unsigned m_pc4;
    bit          m_valid;
    bit          m_mis;
    int unsigned m_cnt;

    if_stage #(.PC_RESET(32'h0), .MEM_BYTES(MEM_BYTES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_addr  (instr_addr),
        .instr       (instr),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .misalign    (misalign),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input int unsigned a);
        int unsigned b;
        b = a % MEM_BYTES;
        return {mem[b], mem[(b + 1) % MEM_BYTES], mem[(b + 2) % MEM_BYTES],
                mem[(b + 3) % MEM_BYTES]};
    endfunction

    // Big-endian combinational instruction memory
    always_comb instr = word_at(int'(instr_addr));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_boot = 1; m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_mis = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        if (m_boot) begin
            m_boot = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else if (redirect) begin
            m_pc    = (int'(redirect_pc) - int'(redirect_pc) % 4);
            m_pc    = (redirect_pc - redirect_pc % 4) % MEM_BYTES;
            m_instr = 0; m_pc4 = 0; m_valid = 0;
            if (redirect_pc % 4 != 0) m_mis = 1;
        end else if (!stall) begin
            m_instr = word_at(m_pc);
            m_pc4   = m_pc + 4;
            m_valid = 1;
            m_pc    = (m_pc + 4) % MEM_BYTES;
            m_cnt   = m_cnt + 1;
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".addr"},  instr_addr,          m_pc);
        chk({ctx, ".instr"}, if_id_instr,         m_instr);
        chk({ctx, ".pc4"},   if_id_pc4,           m_pc4);
        chk({ctx, ".valid"}, 32'(if_id_valid),    32'(m_valid));
        chk({ctx, ".mis"},   32'(misalign),       32'(m_mis));
        chk({ctx, ".cnt"},   fetch_count,         m_cnt);
    endtask

    task automatic step(input string ctx);
        @(posedge clk);
        model_edge();
        #1;
        check_all(ctx);
    endtask

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);
        {mem[0], mem[1], mem[2], mem[3]} = 32'h2008_0005;
        {mem[4], mem[5], mem[6], mem[7]} = 32'h2009_0003;

        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        model_reset();
        #3;
        chk("rst.addr",  instr_addr, 32'h0);
        chk("rst.valid", 32'(if_id_valid), 32'h0);
        chk("rst.cnt",   fetch_count, 32'h0);
        rst_n = 1'b1;

        step("boot");
        chk("boot.valid", 32'(if_id_valid), 32'h0);
        chk("boot.addr",  instr_addr, 32'h0);

        step("seq0");
        step("seq1");
        chk("seq.instr", if_id_instr, 32'h2009_0003);
        chk("seq.pc4",   if_id_pc4,   32'd8);
        chk("seq.addr",  instr_addr,  32'd8);
        chk("seq.cnt",   fetch_count, 32'd2);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("stall");
            chk("stall.addr",  instr_addr,  32'd8);
            chk("stall.instr", if_id_instr, 32'h2009_0003);
            chk("stall.pc4",   if_id_pc4,   32'd8);
        end
        stall = 1'b0;
        step("unstall");
        chk("unstall.addr", instr_addr, 32'd12);

        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h40;
        step("redir");
        chk("redir.addr",  instr_addr, 32'h40);
        chk("redir.valid", 32'(if_id_valid), 32'h0);
        chk("redir.instr", if_id_instr, 32'h0);
        redirect = 1'b0; stall = 1'b0;
        step("post_redir");
        chk("post_redir.valid", 32'(if_id_valid), 32'h1);
        chk("post_redir.pc4",   if_id_pc4, 32'h44);

        for (int i = 0; i < 64 && m_pc != 124; i++) step("run");
        chk("run.addr124", instr_addr, 32'd124);
        step("wrap");
        chk("wrap.addr", instr_addr, 32'h0);
        chk("wrap.pc4",  if_id_pc4,  32'd128);

        redirect = 1'b1; redirect_pc = 32'h16;
        step("misal");
        chk("misal.addr", instr_addr, 32'h14);
        chk("misal.flag", 32'(misalign), 32'h1);
        redirect = 1'b0;
        for (int i = 0; i < 4; i++) step("misal_hold");
        chk("misal.sticky", 32'(misalign), 32'h1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 255));
            step("rand");
        end

        redirect = 1'b1; stall = 1'b0; redirect_pc = 32'h20;
        step("to20");
        redirect = 1'b0;
        chk("to20.addr", instr_addr, 32'h20);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst.addr",  instr_addr, 32'h0);
        chk("arst.valid", 32'(if_id_valid), 32'h0);
        chk("arst.cnt",   fetch_count, 32'h0);
        chk("arst.mis",   32'(misalign), 32'h0);
        chk("arst.instr", if_id_instr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step("reboot");
        for (int i = 0; i < 100; i++) begin
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 7) == 0);
            redirect_pc = $urandom;
            step("rand2");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
